// File: rtl/mil_transmitter.sv
// ---------------------------------------------------------------------------
// mil_transmitter
//   Sends one MIL-STD-1553 style word per accepted request. Each word is
//   40 Manchester half-bits, and every half-bit lasts HALF_BIT clocks.
//     half-bits  0..5  : sync (111000 command/status, 000111 data)
//     half-bits  6..37 : in_word[15] down to in_word[0], 1 -> 10, 0 -> 01
//     half-bits 38..39 : odd parity bit over the 17 bits, same encoding
//
// Ports
//   clk       system clock, all logic on posedge
//   rst       synchronous active-high reset
//   enable    gates acceptance of new words; a word in flight always completes
//   in_valid  a word is offered
//   in_sync   1 = command/status sync, 0 = data sync
//   in_word   16-bit payload, MSB first on the line
//   in_ready  word accepted on the clock where in_valid & in_ready
//   TXout     positive line drive (current half-bit while sending, else 0)
//   nTXout    negative line drive (complement while sending, else 0)
//   busy      a word is on the line
// ---------------------------------------------------------------------------
module mil_transmitter #(
    parameter int HALF_BIT = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic        in_sync,
    input  logic [15:0] in_word,
    output logic        in_ready,
    output logic        TXout,
    output logic        nTXout,
    output logic        busy
);

    localparam int          CNT_W    = 8;                 // covers HALF_BIT up to 255
    localparam int          FRAME_W  = 40;
    localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HALF_BIT - 1);
    localparam logic [5:0]       IDX_LAST = 6'd39;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic        sync;
        logic [15:0] word;
    } mil_req_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   hb_cnt;      // clock within the current half-bit
    logic [5:0]         hb_idx;      // half-bit index 0..39
    logic [FRAME_W-1:0] tx_sr;       // latched frame, bit 39 is on the line
    logic               hb_end;
    logic               word_end;
    logic               accept;
    mil_req_t           req;

    // Whole frame is built at accept time, so later input changes cannot
    // leak into a word already in flight.
    function automatic logic [FRAME_W-1:0] build_frame(input mil_req_t r);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[39:34] = r.sync ? 6'b111000 : 6'b000111;
        for (int k = 0; k < 16; k++) begin
            f[33 - 2*k -: 2] = r.word[15 - k] ? 2'b10 : 2'b01;
        end
        f[1:0] = (~^r.word) ? 2'b10 : 2'b01;
        return f;
    endfunction

    assign req = '{sync: in_sync, word: in_word};

    always_comb begin
        hb_end   = (hb_cnt == HB_LAST);
        word_end = (state == SEND) && hb_end && (hb_idx == IDX_LAST);
        // Ready only when the line is free on the next clock: idle, or the
        // very last clock of half-bit 39, which gives gapless back-to-back words.
        in_ready = enable && !rst && ((state == IDLE) || word_end);
        accept   = in_valid && in_ready;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (word_end && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // half-bit timer, index and frame shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
            hb_idx <= '0;
            tx_sr  <= '0;
        end else if (accept) begin
            hb_cnt <= '0;
            hb_idx <= '0;
            tx_sr  <= build_frame(req);
        end else if (state == SEND) begin
            if (hb_end) begin
                hb_cnt <= '0;
                hb_idx <= word_end ? 6'd0 : hb_idx + 6'd1;
                tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
            end else begin
                hb_cnt <= hb_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs decode registered state only, so no glitch cycle between words.
    always_comb begin
        busy   = (state == SEND);
        TXout  = busy &  tx_sr[FRAME_W-1];
        nTXout = busy & ~tx_sr[FRAME_W-1];
    end

endmodule
